avalon_mem_arbiter: RTL and testbench
=====================================

// Module: avalon_mem_arbiter
// PURPOSE
//  Shares the single Avalon-MM memory slave (RAM) between the CPU instruction-fetch port (m0)
//  and the load/store data port (m1). Round-robin grant, waitrequest pass-through to the owner,
//  stall of the loser, watchdog on a stuck slave. Sits between top_level_CPU and RAM.
// PARAMETERS
//  ADDR_W   32   address width, both masters and slave
//  DATA_W   32   data width; byteenable width = DATA_W/8
//  TIMEOUT  64   max consecutive slave waitrequest cycles before abort (>=2)
// PORTS
//  clk             in   1        rising-edge clock
//  reset           in   1        synchronous, active-high
//  m0_address      in   ADDR_W   fetch address
//  m0_read         in   1        fetch request (read-only master)
//  m0_waitrequest  out  1        stall to fetch master
//  m0_readdata     out  DATA_W   fetch data
//  m1_address      in   ADDR_W   data address
//  m1_read         in   1        data read request
//  m1_write        in   1        data write request (never with m1_read)
//  m1_writedata    in   DATA_W   store data
//  m1_byteenable   in   DATA_W/8 store/load lanes
//  m1_waitrequest  out  1        stall to data master
//  m1_readdata     out  DATA_W   load data
//  address         out  ADDR_W   to slave
//  read/write      out  1 each   to slave
//  writedata       out  DATA_W   to slave
//  byteenable      out  DATA_W/8 to slave
//  waitrequest     in   1        from slave
//  readdata        in   DATA_W   from slave
//  grant           out  2        one-hot owner: 01=m0, 10=m1, 00=none
//  bus_error       out  1        sticky watchdog flag
// BEHAVIOUR
//  Reset values: state IDLE, grant=00, read=write=0, m0/m1_waitrequest=1, bus_error=0,
//   round-robin pointer favours m0, wait counter 0. Reset mid-transfer aborts it silently.
//  Request: req0=m0_read; req1=m1_read|m1_write. Masters hold all signals while waitrequest=1.
//  FSM IDLE -> OWN0/OWN1 (registered grant; 1-cycle arbitration latency from IDLE):
//   IDLE: only one req -> grant it; both -> grant side opposite to last-served (m0 after reset).
//   OWNn: slave signals = master n's, combinationally; m0 drives byteenable all-ones, write=0.
//    mn_waitrequest = waitrequest; other master's waitrequest = 1; readdata fans out to both.
//   Completion: granted req high and waitrequest=0 on an edge. Last-served <= n. Next state:
//    other master requesting -> OWN(other) (back-to-back, no idle cycle); else IDLE.
//    Same master requesting again with other idle -> IDLE (re-arbitrates next cycle).
//   Granted req drops without completion (protocol violation) -> IDLE, no pointer update.
//  Watchdog: counter increments each OWNn cycle with waitrequest=1, clears on completion/IDLE.
//   Reaching TIMEOUT: bus_error<=1 (sticky until reset), owner gets one cycle of
//   waitrequest=0 with readdata forced to 0 (write dropped), pointer updated, -> IDLE.
//  Outside OWNn: read=write=0; address/writedata/byteenable hold last values (don't-care).
//  grant is a state decode; no combinational path from any m*_read/write to grant.
// TESTING
//  1 m0_read@0x04, RAM zero-wait -> grant=01 one cycle after request, m0_waitrequest low, data 0x2404FFFF.
//  2 m0_read+m1_read same cycle, repeated -> grants 01,10,01,10 back-to-back, no IDLE gap.
//  3 m1_write 0x10, be=4'b0011, slave waitrequest high 3 cycles -> write held 4 cycles, m0 stalled.
//  4 slave waitrequest stuck high, TIMEOUT=8 -> bus_error=1 after 8 wait cycles, owner released, readdata 0.
//  5 reset pulsed during OWN1 -> next cycle read=write=0, grant=00, bus_error=0, m0 wins next tie.
//  6 m1_read drops mid-wait -> IDLE next cycle, pending m0 granted following cycle.

Source files
------------

// File: rtl/avalon_mem_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM slave between fetch (m0) and load/store (m1); 1-cycle grant from IDLE.
// Owner sees slave waitrequest directly; the other master is held stalled; stuck slave aborts after TIMEOUT waits.
module avalon_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W/8-1:0] byteenable,
    input  logic                waitrequest,
    input  logic [DATA_W-1:0]   readdata,
    output logic [1:0]          grant,
    output logic                bus_error
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, OWN0, OWN1, ABORT0, ABORT1} state_t;

    state_t           state;
    logic             last_m1;
    logic             sel_m1;
    logic [CNT_W-1:0] wait_cnt;
    logic             req0;
    logic             req1;
    logic             wdog_hit;

    assign req0     = m0_read;
    assign req1     = m1_read | m1_write;
    assign wdog_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

    // sel_m1 only changes on a new grant, so the slave-side mux holds its source while idle
    assign address    = sel_m1 ? m1_address : m0_address;
    assign byteenable = sel_m1 ? m1_byteenable : {BE_W{1'b1}};
    assign writedata  = m1_writedata;
    assign read       = (state == OWN0) ? m0_read : ((state == OWN1) ? m1_read : 1'b0);
    assign write      = (state == OWN1) & m1_write;

    assign m0_waitrequest = (state == OWN0) ? waitrequest : (state != ABORT0);
    assign m1_waitrequest = (state == OWN1) ? waitrequest : (state != ABORT1);
    assign m0_readdata    = (state == ABORT0 || state == ABORT1) ? '0 : readdata;
    assign m1_readdata    = (state == ABORT0 || state == ABORT1) ? '0 : readdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= 2'b00;
            last_m1   <= 1'b1;
            sel_m1    <= 1'b0;
            wait_cnt  <= '0;
            bus_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (req0 && (!req1 || last_m1)) begin
                        state  <= OWN0;
                        grant  <= 2'b01;
                        sel_m1 <= 1'b0;
                    end else if (req1) begin
                        state  <= OWN1;
                        grant  <= 2'b10;
                        sel_m1 <= 1'b1;
                    end
                end
                OWN0: begin
                    if (!req0) begin
                        state    <= IDLE;
                        grant    <= 2'b00;
                        wait_cnt <= '0;
                    end else if (!waitrequest) begin
                        last_m1  <= 1'b0;
                        wait_cnt <= '0;
                        if (req1) begin
                            state  <= OWN1;
                            grant  <= 2'b10;
                            sel_m1 <= 1'b1;
                        end else begin
                            state <= IDLE;
                            grant <= 2'b00;
                        end
                    end else if (wdog_hit) begin
                        bus_error <= 1'b1;
                        state     <= ABORT0;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                OWN1: begin
                    if (!req1) begin
                        state    <= IDLE;
                        grant    <= 2'b00;
                        wait_cnt <= '0;
                    end else if (!waitrequest) begin
                        last_m1  <= 1'b1;
                        wait_cnt <= '0;
                        if (req0) begin
                            state  <= OWN0;
                            grant  <= 2'b01;
                            sel_m1 <= 1'b0;
                        end else begin
                            state <= IDLE;
                            grant <= 2'b00;
                        end
                    end else if (wdog_hit) begin
                        bus_error <= 1'b1;
                        state     <= ABORT1;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ABORT0: begin
                    last_m1 <= 1'b0;
                    state   <= IDLE;
                    grant   <= 2'b00;
                end
                ABORT1: begin
                    last_m1 <= 1'b1;
                    state   <= IDLE;
                    grant   <= 2'b00;
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Directed bench for avalon_mem_arbiter with a small word-addressed RAM model on the slave side.
module tb_avalon_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_address;
    logic        m0_read;
    logic        m0_waitrequest;
    logic [31:0] m0_readdata;
    logic [31:0] m1_address;
    logic        m1_read;
    logic        m1_write;
    logic [31:0] m1_writedata;
    logic [3:0]  m1_byteenable;
    logic        m1_waitrequest;
    logic [31:0] m1_readdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic [1:0]  grant;
    logic        bus_error;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [0:15];

    avalon_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
        .grant(grant), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    always_comb begin
        readdata = 32'hBAD0_BAD0;
        if (address[31:6] == 26'd0 && address[1:0] == 2'd0)
            readdata = mem[address[5:2]];
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[1] <= 32'h2404_FFFF;
            mem[4] <= 32'hDEAD_BEEF;
        end else if (write && !waitrequest) begin
            for (int b = 0; b < 4; b++)
                if (byteenable[b]) mem[address[5:2]][b*8 +: 8] <= writedata[b*8 +: 8];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset();
        #1;
        vectors++;
        if ({grant, read, write, m0_waitrequest, m1_waitrequest, bus_error} !== 7'b00_0_0_1_1_0) begin
            miscompares++;
            $display("FAIL reset_state: got grant=%b rd=%b wr=%b w0=%b w1=%b err=%b, expected 00 0 0 1 1 0",
                     grant, read, write, m0_waitrequest, m1_waitrequest, bus_error);
        end
    endtask

    task automatic test_single_read;
        m0_address  = 32'h04;
        m0_read     = 1'b1;
        waitrequest = 1'b0;
        #1;
        vectors++;
        if (grant !== 2'b00 || m0_waitrequest !== 1'b1 || read !== 1'b0) begin
            miscompares++;
            $display("FAIL single_arb_latency: got grant=%b w0=%b rd=%b, expected 00 1 0", grant, m0_waitrequest, read);
        end
        tick();
        vectors++;
        if (grant !== 2'b01 || m0_waitrequest !== 1'b0 || read !== 1'b1 || write !== 1'b0 || byteenable !== 4'hF) begin
            miscompares++;
            $display("FAIL single_grant: got grant=%b w0=%b rd=%b wr=%b be=%h, expected 01 0 1 0 f",
                     grant, m0_waitrequest, read, write, byteenable);
        end
        vectors++;
        if (m0_readdata !== 32'h2404_FFFF) begin
            miscompares++;
            $display("FAIL single_data: got %h expected 2404ffff", m0_readdata);
        end
        tick();
        m0_read = 1'b0;
        #1;
        vectors++;
        if (grant !== 2'b00) begin
            miscompares++;
            $display("FAIL single_release: got grant=%b expected 00", grant);
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp_grant [4];
        exp_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
        apply_reset();
        m0_address = 32'h04;
        m1_address = 32'h10;
        m0_read    = 1'b1;
        m1_read    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (grant !== exp_grant[i]) begin
                miscompares++;
                $display("FAIL rr_grant_%0d: got %b expected %b", i, grant, exp_grant[i]);
            end
            vectors++;
            if ((exp_grant[i] == 2'b01 ? m1_waitrequest : m0_waitrequest) !== 1'b1) begin
                miscompares++;
                $display("FAIL rr_loser_stall_%0d: got w0=%b w1=%b, expected loser waitrequest 1",
                         i, m0_waitrequest, m1_waitrequest);
            end
            if (i == 3) m0_read = 1'b0;
        end
        tick();
        m1_read = 1'b0;
        #1;
        vectors++;
        if (grant !== 2'b00) begin
            miscompares++;
            $display("FAIL rr_release: got grant=%b expected 00", grant);
        end
    endtask

    task automatic test_write_wait;
        int wcount;
        wcount        = 0;
        m1_address    = 32'h10;
        m1_writedata  = 32'hA5A5_1234;
        m1_byteenable = 4'b0011;
        m1_write      = 1'b1;
        waitrequest   = 1'b1;
        tick();
        m0_address = 32'h04;
        m0_read    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            waitrequest = (i < 3);
            #1;
            if (write) wcount++;
            vectors++;
            if (m0_waitrequest !== 1'b1 || m1_waitrequest !== waitrequest || grant !== 2'b10) begin
                miscompares++;
                $display("FAIL wr_stall_%0d: got w0=%b w1=%b grant=%b, expected 1 %b 10",
                         i, m0_waitrequest, m1_waitrequest, grant, waitrequest);
            end
            if (i == 0) begin
                vectors++;
                if (address !== 32'h10 || byteenable !== 4'b0011 || writedata !== 32'hA5A5_1234) begin
                    miscompares++;
                    $display("FAIL wr_bus: got addr=%h be=%b wd=%h, expected 10 0011 a5a51234",
                             address, byteenable, writedata);
                end
            end
            tick();
        end
        m1_write    = 1'b0;
        waitrequest = 1'b0;
        #1;
        vectors++;
        if (wcount !== 4) begin
            miscompares++;
            $display("FAIL wr_hold_cycles: got %0d expected 4", wcount);
        end
        vectors++;
        if (mem[4] !== 32'hDEAD_1234) begin
            miscompares++;
            $display("FAIL wr_lanes: got %h expected dead1234", mem[4]);
        end
        vectors++;
        if (grant !== 2'b01 || m0_readdata !== 32'h2404_FFFF || m0_waitrequest !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_handoff: got grant=%b data=%h w0=%b, expected 01 2404ffff 0",
                     grant, m0_readdata, m0_waitrequest);
        end
        tick();
        m0_read = 1'b0;
        #1;
        vectors++;
        if (grant !== 2'b00) begin
            miscompares++;
            $display("FAIL wr_release: got grant=%b expected 00", grant);
        end
    endtask

    task automatic test_watchdog;
        m0_address  = 32'h04;
        m0_read     = 1'b1;
        waitrequest = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (bus_error !== 1'b0 || m0_waitrequest !== 1'b1) begin
                miscompares++;
                $display("FAIL wdog_wait_%0d: got err=%b w0=%b, expected 0 1", i, bus_error, m0_waitrequest);
            end
            tick();
        end
        vectors++;
        if (bus_error !== 1'b1 || m0_waitrequest !== 1'b0 || read !== 1'b0 || grant !== 2'b01) begin
            miscompares++;
            $display("FAIL wdog_abort: got err=%b w0=%b rd=%b grant=%b, expected 1 0 0 01",
                     bus_error, m0_waitrequest, read, grant);
        end
        vectors++;
        if (m0_readdata !== 32'h0) begin
            miscompares++;
            $display("FAIL wdog_data: got %h expected 00000000", m0_readdata);
        end
        tick();
        m0_read     = 1'b0;
        waitrequest = 1'b0;
        #1;
        vectors++;
        if (grant !== 2'b00 || bus_error !== 1'b1 || m0_waitrequest !== 1'b1) begin
            miscompares++;
            $display("FAIL wdog_sticky: got grant=%b err=%b w0=%b, expected 00 1 1", grant, bus_error, m0_waitrequest);
        end
    endtask

    task automatic test_reset_mid_transfer;
        m1_address  = 32'h10;
        m1_read     = 1'b1;
        waitrequest = 1'b1;
        tick();
        vectors++;
        if (grant !== 2'b10 || read !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_own1: got grant=%b rd=%b, expected 10 1", grant, read);
        end
        reset   = 1'b1;
        m0_read = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        vectors++;
        if (read !== 1'b0 || write !== 1'b0 || grant !== 2'b00 || bus_error !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_abort: got rd=%b wr=%b grant=%b err=%b, expected 0 0 00 0",
                     read, write, grant, bus_error);
        end
        waitrequest = 1'b0;
        tick();
        vectors++;
        if (grant !== 2'b01) begin
            miscompares++;
            $display("FAIL rst_tie_m0: got grant=%b expected 01", grant);
        end
        tick();
        m0_read = 1'b0;
        #1;
        vectors++;
        if (grant !== 2'b10) begin
            miscompares++;
            $display("FAIL rst_then_m1: got grant=%b expected 10", grant);
        end
        tick();
        m1_read = 1'b0;
        #1;
    endtask

    task automatic test_req_drop;
        m1_address  = 32'h10;
        m1_read     = 1'b1;
        waitrequest = 1'b1;
        tick();
        m0_address = 32'h04;
        m0_read    = 1'b1;
        tick();
        vectors++;
        if (grant !== 2'b10 || m0_waitrequest !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_own1: got grant=%b w0=%b, expected 10 1", grant, m0_waitrequest);
        end
        m1_read = 1'b0;
        tick();
        vectors++;
        if (grant !== 2'b00 || read !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_idle: got grant=%b rd=%b, expected 00 0", grant, read);
        end
        tick();
        vectors++;
        if (grant !== 2'b01) begin
            miscompares++;
            $display("FAIL drop_m0_next: got grant=%b expected 01", grant);
        end
        waitrequest = 1'b0;
        tick();
        m0_read = 1'b0;
        #1;
        vectors++;
        if (grant !== 2'b00) begin
            miscompares++;
            $display("FAIL drop_release: got grant=%b expected 00", grant);
        end
    endtask

    initial begin
        reset         = 1'b1;
        m0_address    = '0;
        m0_read       = 1'b0;
        m1_address    = '0;
        m1_read       = 1'b0;
        m1_write      = 1'b0;
        m1_writedata  = '0;
        m1_byteenable = '0;
        waitrequest   = 1'b0;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_write_wait();
        test_watchdog();
        test_reset_mid_transfer();
        test_req_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
